// File: rtl/barker_pkg.sv
// Shared constants and types for the Barker-11 frame synchroniser.
package barker_pkg;

  localparam int unsigned BARKER_LEN = 11;
  localparam logic [BARKER_LEN-1:0] BARKER_SEQ = 11'b11100010010;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } sync_state_t;

endpackage

// File: rtl/barker_frame_sync.sv
// Frame-sync flywheel around the Barker-11 correlator: HUNT/VERIFY/LOCK on
// matches FRAME_LEN bits apart, one event per expected sync position.
module barker_frame_sync
  import barker_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 64,
  parameter int unsigned VERIFY_CNT = 2,
  parameter int unsigned MISS_CNT   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        c_tdata,
  output logic        c_tvalid,
  output logic        c_tlast,
  input  logic        c_tready,
  input  logic        r_tuser,
  input  logic        r_tvalid,
  output logic        r_tready,
  output logic        m_tvalid,
  output logic        m_tuser,
  input  logic        m_tready,
  output logic        o_locked,
  output logic [15:0] o_frame_cnt
);

  localparam int unsigned CNT_W  = $clog2(FRAME_LEN);
  localparam int unsigned HIT_W  = $clog2(VERIFY_CNT + 1);
  localparam int unsigned MISS_W = $clog2(MISS_CNT + 1);

  sync_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_pos, w_pos_nxt;
  logic [HIT_W-1:0]  r_hits, w_hits_nxt;
  logic [MISS_W-1:0] r_misses, w_misses_nxt;
  logic              r_m_tvalid, r_m_tuser, r_locked;
  logic [15:0]       r_frame_cnt;
  logic              w_take, w_window, w_ev, w_ev_user;

  // Bit stream goes straight through to the correlator.
  assign c_tdata  = s_tdata;
  assign c_tvalid = s_tvalid;
  assign c_tlast  = s_tlast;
  assign s_tready = c_tready;

  // Stall results only while an undelivered event blocks the register.
  assign r_tready = !(r_m_tvalid && !m_tready);
  assign w_take   = r_tvalid && r_tready;
  assign w_window = (r_pos == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= HUNT;
      r_pos    <= '0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pos    <= w_pos_nxt;
      r_hits   <= w_hits_nxt;
      r_misses <= w_misses_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_nxt    = r_pos;
    w_hits_nxt   = r_hits;
    w_misses_nxt = r_misses;
    w_ev         = 1'b0;
    w_ev_user    = 1'b0;
    if (w_take) begin
      unique case (r_state)
        HUNT: begin
          if (r_tuser) begin
            w_pos_nxt   = '0;
            w_hits_nxt  = HIT_W'(1);
            w_state_nxt = (VERIFY_CNT == 1) ? LOCK : VERIFY;
          end
        end
        VERIFY: begin
          if (!w_window) begin
            w_pos_nxt = r_pos + CNT_W'(1);
          end else if (r_tuser) begin
            w_pos_nxt  = '0;
            w_hits_nxt = r_hits + HIT_W'(1);
            if (r_hits + HIT_W'(1) == HIT_W'(VERIFY_CNT)) begin
              w_state_nxt = LOCK;
              w_ev        = 1'b1;
              w_ev_user   = 1'b1;
            end
          end else begin
            w_pos_nxt   = '0;
            w_hits_nxt  = '0;
            w_state_nxt = HUNT;
          end
        end
        LOCK: begin
          // Matches between windows are false syncs and are ignored.
          if (!w_window) begin
            w_pos_nxt = r_pos + CNT_W'(1);
          end else begin
            w_pos_nxt = '0;
            w_ev      = 1'b1;
            w_ev_user = r_tuser;
            if (r_tuser) begin
              w_misses_nxt = '0;
            end else if (r_misses + MISS_W'(1) == MISS_W'(MISS_CNT)) begin
              w_misses_nxt = '0;
              w_hits_nxt   = '0;
              w_state_nxt  = HUNT;
            end else begin
              w_misses_nxt = r_misses + MISS_W'(1);
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // One-deep event register; can drain and reload in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_m_tvalid  <= 1'b0;
      r_m_tuser   <= 1'b0;
      r_locked    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_locked <= (w_state_nxt == LOCK);
      if (w_ev) begin
        r_m_tvalid  <= 1'b1;
        r_m_tuser   <= w_ev_user;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign m_tvalid    = r_m_tvalid;
  assign m_tuser     = r_m_tuser;
  assign o_locked    = r_locked;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_barker_frame_sync.sv
// Bench for barker_frame_sync: directed match patterns with random handshakes,
// checked against an anchor-index model of the sync flywheel.
module tb_barker_frame_sync;

  localparam int FRAME_LEN  = 64;
  localparam int VERIFY_CNT = 2;
  localparam int MISS_CNT   = 3;
  localparam int MAX_RES    = 1024;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        s_tdata, s_tvalid, s_tlast, s_tready;
  logic        c_tdata, c_tvalid, c_tlast, c_tready;
  logic        r_tuser, r_tvalid, r_tready;
  logic        m_tvalid, m_tuser, m_tready;
  logic        o_locked;
  logic [15:0] o_frame_cnt;

  int n_pass  = 0;
  int n_total = 0;

  bit flags  [MAX_RES];
  bit exp_ev [MAX_RES];
  bit exp_evu[MAX_RES];
  bit exp_lk [MAX_RES];

  int exp_fc;
  bit exp_mv;
  bit exp_mu;

  barker_frame_sync #(
    .FRAME_LEN (FRAME_LEN),
    .VERIFY_CNT(VERIFY_CNT),
    .MISS_CNT  (MISS_CNT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .c_tdata    (c_tdata),
    .c_tvalid   (c_tvalid),
    .c_tlast    (c_tlast),
    .c_tready   (c_tready),
    .r_tuser    (r_tuser),
    .r_tvalid   (r_tvalid),
    .r_tready   (r_tready),
    .m_tvalid   (m_tvalid),
    .m_tuser    (m_tuser),
    .m_tready   (m_tready),
    .o_locked   (o_locked),
    .o_frame_cnt(o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_flags();
    for (int i = 0; i < MAX_RES; i++) flags[i] = 1'b0;
  endtask

  // Flywheel expressed by result index: a window is the FRAME_LEN-th result after the anchor.
  task automatic build_model(input int n_res);
    int mode, anchor, hits, misses;
    mode = 0; anchor = 0; hits = 0; misses = 0;
    for (int n = 0; n < n_res; n++) begin
      exp_ev[n]  = 1'b0;
      exp_evu[n] = 1'b0;
      if (mode == 0) begin
        if (flags[n]) begin
          anchor = n;
          hits   = 1;
          mode   = (VERIFY_CNT == 1) ? 2 : 1;
        end
      end else if (n - anchor == FRAME_LEN) begin
        anchor = n;
        if (mode == 1) begin
          if (flags[n]) begin
            hits++;
            if (hits == VERIFY_CNT) begin
              mode = 2; exp_ev[n] = 1'b1; exp_evu[n] = 1'b1;
            end
          end else begin
            mode = 0; hits = 0;
          end
        end else begin
          exp_ev[n]  = 1'b1;
          exp_evu[n] = flags[n];
          if (flags[n]) misses = 0;
          else begin
            misses++;
            if (misses == MISS_CNT) begin
              mode = 0; misses = 0; hits = 0;
            end
          end
        end
      end
      exp_lk[n] = (mode == 2);
    end
  endtask

  task automatic check_passthrough(input string tag);
    s_tdata  = 1'($urandom); s_tvalid = 1'($urandom);
    s_tlast  = 1'($urandom); c_tready = 1'($urandom);
    #1;
    chk({tag, "_c_tdata"},  32'(c_tdata),  32'(s_tdata));
    chk({tag, "_c_tvalid"}, 32'(c_tvalid), 32'(s_tvalid));
    chk({tag, "_c_tlast"},  32'(c_tlast),  32'(s_tlast));
    chk({tag, "_s_tready"}, 32'(s_tready), 32'(c_tready));
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0; r_tvalid = 1'b0; r_tuser = 1'b0; m_tready = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tuser",  32'(m_tuser),  32'd0);
    chk("rst_locked",   32'(o_locked), 32'd0);
    chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    i_rst_n = 1'b1;
    exp_fc = 0; exp_mv = 1'b0; exp_mu = 1'b0;
  endtask

  // Feeds n_res results with random valid/ready gaps; checks every cycle.
  task automatic run_seq(input int n_res, input bit stall_en,
                         input int vld_pct, input int rdy_pct);
    int  ridx = 0;
    int  last_take = -1;
    int  stall = 0;
    int  cyc = 0;
    int  budget = n_res * 20 + 200;
    bit  take;
    build_model(n_res);
    while ((ridx < n_res || last_take >= 0) && cyc < budget) begin
      @(negedge i_clk);
      cyc++;
      if (last_take >= 0) begin
        if (exp_ev[last_take]) begin
          exp_fc = (exp_fc + 1) & 16'hFFFF;
          exp_mv = 1'b1;
          exp_mu = exp_evu[last_take];
          if (stall_en) stall = 10;
        end
        chk("frame_cnt", 32'(o_frame_cnt), 32'(exp_fc));
        chk("locked",    32'(o_locked),    32'(exp_lk[last_take]));
      end
      chk("m_tvalid", 32'(m_tvalid), 32'(exp_mv));
      if (exp_mv) chk("m_tuser", 32'(m_tuser), 32'(exp_mu));
      r_tvalid = (ridx < n_res) && (($urandom % 100) < vld_pct);
      r_tuser  = r_tvalid ? flags[ridx] : 1'($urandom);
      if (stall > 0) begin
        m_tready = 1'b0;
        stall--;
      end else begin
        m_tready = (($urandom % 100) < rdy_pct);
      end
      #1;
      chk("r_tready", 32'(r_tready), 32'(!(exp_mv && !m_tready)));
      take = r_tvalid && r_tready;
      if (exp_mv && m_tready) exp_mv = 1'b0;
      last_take = take ? ridx : -1;
      if (take) ridx++;
    end
    if (cyc >= budget) chk("timeout", 32'd0, 32'd1);
    @(negedge i_clk);
    r_tvalid = 1'b0;
    m_tready = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    s_tdata = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; c_tready = 1'b0;
    r_tvalid = 1'b0; r_tuser = 1'b0; m_tready = 1'b0;
    exp_fc = 0; exp_mv = 1'b0; exp_mu = 1'b0;

    do_reset();
    for (int i = 0; i < 4; i++) check_passthrough("pass");

    // Lock, false sync inside a frame, three missed frames, re-acquire.
    clear_flags();
    flags[11] = 1; flags[75] = 1; flags[105] = 1; flags[139] = 1; flags[203] = 1;
    flags[400] = 1; flags[464] = 1;
    run_seq(500, 1'b1, 70, 60);
    chk("seqA_total_events", 32'(o_frame_cnt), 32'd7);

    // Single hunt match with no confirmation: no event, never locked.
    do_reset();
    clear_flags();
    flags[11] = 1;
    run_seq(150, 1'b0, 80, 50);
    chk("seqB_no_events", 32'(o_frame_cnt), 32'd0);

    // Lock then pulse reset while locked.
    do_reset();
    clear_flags();
    flags[11] = 1; flags[75] = 1;
    run_seq(100, 1'b0, 90, 90);
    chk("seqC_locked_before_rst", 32'(o_locked), 32'd1);
    do_reset();

    // Periodic syncs with some dropped, plus random noise matches.
    clear_flags();
    for (int n = 20; n < 900; n += FRAME_LEN)
      if (($urandom % 5) != 0) flags[n] = 1;
    for (int n = 0; n < 900; n++)
      if (($urandom % 20) == 0) flags[n] = 1;
    run_seq(900, 1'b0, 75, 70);

    for (int i = 0; i < 4; i++) check_passthrough("pass_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
